// File: rtl/fabric_config_loader.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : fabric_config_loader
// Purpose  : Word-serial eFPGA bitstream loader. Assembles NUM_ROWS stream
//            words into FrameRegister and strobes one FrameSelect bit.
// Options  : `define FRAME_PARITY_EN adds a per-frame XOR check word.
// Revision : 1.0 - initial release
//============================================================================
module fabric_config_loader #(
    parameter int          NUM_ROWS       = 6,
    parameter int          NUM_COLS       = 8,
    parameter int          FRAMES_PER_COL = 36,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter int          STROBE_CYCLES  = 2
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [31:0]                        s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [NUM_ROWS*32-1:0]             FrameRegister,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0] FrameSelect,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int c_SEL_N = NUM_COLS * FRAMES_PER_COL;
    localparam int c_SEL_W = $clog2(c_SEL_N);
    localparam int c_K_W   = $clog2(NUM_ROWS + 1);
    localparam int c_SC_W  = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
        ST_STROBE = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [NUM_ROWS*32-1:0] r_frame_reg;
    logic [c_SEL_N-1:0]    r_frame_sel;
    logic [2:0]            r_col;
    logic [5:0]            r_frame;
    logic [7:0]            r_cnt;
    logic [c_K_W-1:0]      r_k;
    logic [c_SC_W-1:0]     r_scnt;
`ifdef FRAME_PARITY_EN
    logic [31:0]           r_par;
`endif

    logic                  w_acc;
    logic                  w_sync;
    logic                  w_hdr_bad;
    logic [c_SEL_W-1:0]    w_sel_idx;
    logic [c_SEL_N-1:0]    w_onehot;

    assign w_acc     = s_valid && r_ready;
    assign w_sync    = w_acc && (s_data == SYNC_WORD);
    assign w_hdr_bad = (int'(s_data[10:8]) >= NUM_COLS) || (int'(s_data[5:0]) >= FRAMES_PER_COL);
    assign w_sel_idx = c_SEL_W'(r_col) * c_SEL_W'(FRAMES_PER_COL) + c_SEL_W'(r_frame);

    always_comb begin
        w_onehot            = '0;
        w_onehot[w_sel_idx] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_reg <= '0;
            r_frame_sel <= '0;
            r_col       <= '0;
            r_frame     <= '0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_scnt      <= '0;
`ifdef FRAME_PARITY_EN
            r_par       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_sync) begin
                        r_state <= ST_HDR;
                        r_busy  <= 1'b1;
                    end
                end

                // The count field [23:16] overlaps the desync bit [20]; desync wins.
                ST_HDR: begin
                    if (w_acc) begin
                        if (s_data[20]) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_hdr_bad) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_col   <= s_data[10:8];
                            r_frame <= s_data[5:0];
                            r_cnt   <= s_data[23:16];
                            r_k     <= '0;
`ifdef FRAME_PARITY_EN
                            r_par   <= '0;
`endif
                            r_state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_acc) begin
`ifdef FRAME_PARITY_EN
                        if (int'(r_k) == NUM_ROWS) begin
                            if (s_data == r_par) begin
                                r_state     <= ST_STROBE;
                                r_ready     <= 1'b0;
                                r_frame_sel <= w_onehot;
                                r_scnt      <= c_SC_W'(STROBE_CYCLES - 1);
                            end else begin
                                r_state <= ST_ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_frame_reg[r_k*32 +: 32] <= s_data;
                            r_par                     <= r_par ^ s_data;
                            r_k                       <= r_k + 1'b1;
                        end
`else
                        r_frame_reg[r_k*32 +: 32] <= s_data;
                        if (int'(r_k) == NUM_ROWS - 1) begin
                            r_state     <= ST_STROBE;
                            r_ready     <= 1'b0;
                            r_frame_sel <= w_onehot;
                            r_scnt      <= c_SC_W'(STROBE_CYCLES - 1);
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
`endif
                    end
                end

                ST_STROBE: begin
                    if (r_scnt == '0) begin
                        r_frame_sel <= '0;
                        r_ready     <= 1'b1;
                        r_k         <= '0;
                        r_cnt       <= r_cnt - 1'b1;
`ifdef FRAME_PARITY_EN
                        r_par       <= '0;
`endif
                        if (r_cnt == 8'd0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (int'(r_frame) == FRAMES_PER_COL - 1) begin
                            if (int'(r_col) == NUM_COLS - 1) begin
                                r_state <= ST_ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_col   <= r_col + 1'b1;
                                r_frame <= '0;
                                r_state <= ST_DATA;
                            end
                        end else begin
                            r_frame <= r_frame + 1'b1;
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_scnt <= r_scnt - 1'b1;
                    end
                end

                ST_ERR: begin
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_frame_sel <= '0;
                    if (w_sync) begin
                        r_state <= ST_HDR;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_frame_sel <= '0;
                end
            endcase
        end
    end

    assign s_ready       = r_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign FrameRegister = r_frame_reg;
    assign FrameSelect   = r_frame_sel;

endmodule
`default_nettype wire

// File: tb/tb_fabric_config_loader.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_fabric_config_loader
// Purpose  : Randomised scoreboard bench for fabric_config_loader.
// Revision : 1.0 - initial release
//============================================================================
module tb_fabric_config_loader;

    localparam int          NUM_ROWS = 6;
    localparam int          NUM_COLS = 8;
    localparam int          FPC      = 36;
    localparam int          SC       = 2;
    localparam logic [31:0] SYNC     = 32'hFAB0_FAB1;
    localparam int          NSEL     = NUM_COLS * FPC;
`ifdef FRAME_PARITY_EN
    localparam bit          PAR       = 1'b1;
    localparam int          FRAME_CYC = NUM_ROWS + 1 + SC;
`else
    localparam bit          PAR       = 1'b0;
    localparam int          FRAME_CYC = NUM_ROWS + SC;
`endif
    localparam int EV_STROBE = 0;
    localparam int EV_DONE   = 1;
    localparam int EV_ERR    = 2;

    logic                   CLK;
    logic                   RST;
    logic [31:0]            s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic [NUM_ROWS*32-1:0] FrameRegister;
    logic [NSEL-1:0]        FrameSelect;
    logic                   busy;
    logic                   done;
    logic                   err;

    fabric_config_loader #(
        .NUM_ROWS       (NUM_ROWS),
        .NUM_COLS       (NUM_COLS),
        .FRAMES_PER_COL (FPC),
        .SYNC_WORD      (SYNC),
        .STROBE_CYCLES  (SC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .FrameRegister (FrameRegister),
        .FrameSelect   (FrameSelect),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    typedef struct {
        int                     kind;
        int                     idx;
        logic [NUM_ROWS*32-1:0] data;
        bit                     tput;
    } ev_t;

    ev_t expq[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    bit  gaps        = 1'b1;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected event per observed strobe/done/err.
    logic [NSEL-1:0]        prev_fs;
    logic [NSEL-1:0]        exp_fs;
    logic [NUM_ROWS*32-1:0] held;
    bit                     prev_err;
    int                     scnt;
    int                     last_rise;
    ev_t                    ev;

    always @(negedge CLK) begin
        if (RST) begin
            prev_fs  = '0;
            prev_err = 1'b0;
            scnt     = 0;
        end else begin
            if (FrameSelect != '0 && prev_fs == '0) begin
                if (expq.size() == 0) begin
                    chk("unexpected strobe", FrameSelect, '0);
                end else begin
                    ev = expq.pop_front();
                    chk("event kind at strobe", ev.kind, EV_STROBE);
                    exp_fs         = '0;
                    exp_fs[ev.idx] = 1'b1;
                    chk("FrameSelect one-hot", FrameSelect, exp_fs);
                    chk("FrameRegister at strobe", FrameRegister, ev.data);
                    if (ev.tput) chk("frame period", cyc - last_rise, FRAME_CYC);
                end
                last_rise = cyc;
                scnt      = 1;
                held      = FrameRegister;
            end else if (FrameSelect != '0) begin
                scnt++;
                chk("FrameSelect held", FrameSelect, prev_fs);
                chk("FrameRegister stable", FrameRegister, held);
            end else if (prev_fs != '0) begin
                chk("strobe length", scnt, SC);
            end
            if (done) begin
                if (expq.size() == 0) chk("unexpected done", done, 1'b0);
                else begin
                    ev = expq.pop_front();
                    chk("event kind at done", ev.kind, EV_DONE);
                    chk("FrameSelect at done", FrameSelect, '0);
                end
            end
            if (err && !prev_err) begin
                if (expq.size() == 0) chk("unexpected err", err, 1'b0);
                else begin
                    ev = expq.pop_front();
                    chk("event kind at err", ev.kind, EV_ERR);
                    chk("FrameSelect at err", FrameSelect, '0);
                end
            end
            prev_fs  = FrameSelect;
            prev_err = err;
        end
    end

    task automatic rword(output logic [31:0] w);
        w = $urandom;
        if (w == SYNC) w = ~w;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] w);
        bit acc;
        int t;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                @(posedge CLK); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = w;
        for (t = 0; t < 1000; t++) begin
            acc = s_ready;
            @(posedge CLK); #1;
            if (acc) break;
        end
        if (t == 1000) chk("handshake timeout", 1, 0);
    endtask

    // Reference model: expected events follow from linear frame addressing.
    task automatic packet(input int col, input int frame, input int n, input bit desync,
                          input int corrupt, input bit seq, input int garbage);
        logic [31:0]            words[$];
        logic [31:0]            w;
        logic [31:0]            hdr;
        logic [31:0]            x;
        logic [NUM_ROWS*32-1:0] fr;
        ev_t                    e;
        bit                     stopped;
        int                     lin;
        for (int i = 0; i < n * NUM_ROWS; i++) begin
            if (seq) w = i + 1;
            else rword(w);
            words.push_back(w);
        end
        hdr        = '0;
        hdr[23:16] = n - 1;
        hdr[20]    = desync;
        hdr[10:8]  = col;
        hdr[5:0]   = frame;
        if (!desync) begin
            if (col >= NUM_COLS || frame >= FPC) begin
                e.kind = EV_ERR; e.idx = 0; e.data = '0; e.tput = 1'b0;
                expq.push_back(e);
            end else begin
                stopped = 1'b0;
                for (int i = 0; i < n && !stopped; i++) begin
                    lin = col * FPC + frame + i;
                    e.idx = lin; e.data = '0; e.tput = 1'b0;
                    if (lin >= NSEL || (PAR && corrupt == i)) begin
                        e.kind  = EV_ERR;
                        stopped = 1'b1;
                    end else begin
                        for (int r = 0; r < NUM_ROWS; r++) fr[r*32 +: 32] = words[i*NUM_ROWS + r];
                        e.kind = EV_STROBE;
                        e.data = fr;
                        e.tput = (i > 0) && !gaps;
                    end
                    expq.push_back(e);
                end
                if (!stopped) begin
                    e.kind = EV_DONE; e.idx = 0; e.data = '0; e.tput = 1'b0;
                    expq.push_back(e);
                end
            end
        end
        for (int g = 0; g < garbage; g++) begin
            rword(w);
            send(w);
        end
        send(SYNC);
        send(hdr);
        for (int i = 0; i < n; i++) begin
            x = '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                send(words[i*NUM_ROWS + r]);
                x = x ^ words[i*NUM_ROWS + r];
            end
            if (PAR) send((corrupt == i) ? (x ^ 32'h0000_0100) : x);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int t;
        for (t = 0; t < 2000; t++) begin
            @(posedge CLK); #1;
            if (expq.size() == 0 && !busy && !s_valid) break;
        end
        chk("drain pending events", expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset s_ready", s_ready, 1'b0);
        chk("reset FrameSelect", FrameSelect, '0);
        chk("reset FrameRegister", FrameRegister, '0);
        chk("reset busy/done/err", {busy, done, err}, 3'b000);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("idle s_ready", s_ready, 1'b1);
        chk("idle busy", busy, 1'b0);

        gaps = 1'b0;
        packet(2, 3, 1, 1'b0, -1, 1'b1, 0);
        wait_quiet();
        packet(0, 35, 2, 1'b0, -1, 1'b0, 0);
        wait_quiet();
        packet(7, 35, 2, 1'b0, -1, 1'b0, 0);
        wait_quiet();
        chk("err after col wrap", err, 1'b1);
        send(SYNC);
        s_valid = 1'b0;
        chk("err cleared by SYNC", err, 1'b0);
        send(32'h0010_0000);
        s_valid = 1'b0;
        wait_quiet();
        packet(7, 36, 1, 1'b0, -1, 1'b0, 1);
        wait_quiet();
        chk("err on bad frame", err, 1'b1);
        chk("FrameSelect in ERR", FrameSelect, '0);
        packet(3, 4, 1, 1'b1, -1, 1'b0, 0);
        wait_quiet();
        chk("busy after desync", busy, 1'b0);
        chk("FrameSelect after desync", FrameSelect, '0);

        if (PAR) begin
            packet(1, 1, 2, 1'b0, 0, 1'b0, 0);
            wait_quiet();
            chk("err on bad parity", err, 1'b1);
        end

        // Reset in the middle of a strobe.
        packet(1, 0, 1, 1'b0, -1, 1'b0, 0);
        chk("strobe active before reset", FrameSelect != '0, 1'b1);
        #2 RST = 1'b1;
        #1;
        expq.delete();
        chk("mid-strobe reset FrameSelect", FrameSelect, '0);
        chk("mid-strobe reset FrameRegister", FrameRegister, '0);
        chk("mid-strobe reset flags", {s_ready, busy, done, err}, 4'b0000);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        packet(4, 10, 1, 1'b0, -1, 1'b0, 0);
        wait_quiet();

        gaps = 1'b1;
        for (int p = 0; p < 40; p++) begin
            packet($urandom_range(0, NUM_COLS - 1), $urandom_range(0, FPC + 1),
                   $urandom_range(1, 4), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
                   1'b0, $urandom_range(0, 2));
        end
        wait_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
